cnf_truth_table_sweeper: RTL and testbench

Sequential harness that exhaustively characterises a generated N_IN-input / N_OUT-output combinational circuit such as the CNF-style netlists in the dataset. It drives every input vector in ascending order and samples the circuit outputs after a programmable settle time. It assembles the captured truth table and compares it against an expected table. It is the reading end of the generated netlists: it consumes their x* inputs and f* outputs and produces their truth table.

---
 rtl/cnf_truth_table_sweeper.sv | 168 ++++++++++++++++
 tb/tb_cnf_truth_table_sweeper.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnf_truth_table_sweeper.sv
// rtl/cnf_truth_table_sweeper.sv - exhaustive truth-table sweeper and checker for an N_IN/N_OUT combinational circuit
//
// Walks every input vector 0 .. 2^N_IN-1 in ascending order on stim. It holds
// each vector for SETTLE+1 cycles and samples resp on the last edge of that
// window. It builds the captured table in tt_out and compares it against exp_tt.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request a sweep; only honoured in IDLE
//   exp_tt     expected table, bit o*2^N_IN+i = expected f_o for vector i
//   stim       circuit inputs, stim[k] drives xk; equals the current vector index
//   resp       circuit outputs, resp[o] is fo
//   busy       high while sweeping
//   done       one-cycle completion pulse
//   pass       1 when no vector mismatched; valid from done until next start
//   tt_out     captured table, same layout as exp_tt
//   fail_cnt   number of vectors with any mismatching output bit
//   first_fail lowest mismatching vector index, 0 if none
module cnf_truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 5,
  parameter int SETTLE = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [N_OUT*(2**N_IN)-1:0]   exp_tt,
  output logic [N_IN-1:0]              stim,
  input  logic [N_OUT-1:0]             resp,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [N_OUT*(2**N_IN)-1:0]   tt_out,
  output logic [N_IN:0]                fail_cnt,
  output logic [N_IN-1:0]              first_fail
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE);
  // idx carries one extra bit so the terminal compare never aliases with 0.
  localparam logic [N_IN:0] IDX_LAST = (N_IN+1)'(NV - 1);
  localparam logic [N_IN:0] FAIL_MAX = (N_IN+1)'(NV);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_IN:0]     idx;
  logic [CW-1:0]     cnt;
  logic [N_IN-1:0]   vidx;
  logic [NV-1:0]     tt_row [N_OUT];
  logic [N_OUT-1:0]  exp_vec;
  logic              sample;
  logic              last;
  logic              mismatch;
  logic [N_IN:0]     fail_nxt;

  assign vidx = idx[N_IN-1:0];

  // Per-output rows: pick the expected bit for the current vector and
  // expose the captured rows in the flat table layout.
  for (genvar o = 0; o < N_OUT; o++) begin : g_row
    logic [NV-1:0] exp_row;
    assign exp_row                = exp_tt[o*NV +: NV];
    assign exp_vec[o]             = exp_row[vidx];
    assign tt_out[o*NV +: NV]     = tt_row[o];
  end

  assign sample   = (state == ST_RUN) && (cnt == CNT_LAST);
  assign last     = (idx == IDX_LAST);
  assign mismatch = (resp != exp_vec);
  assign fail_nxt = (mismatch && (fail_cnt != FAIL_MAX)) ? fail_cnt + 1'b1 : fail_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stim      = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        stim = vidx;
        busy = 1'b1;
        if (sample && last) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      cnt        <= '0;
      pass       <= 1'b0;
      fail_cnt   <= '0;
      first_fail <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        tt_row[o] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx        <= '0;
            cnt        <= '0;
            pass       <= 1'b0;
            fail_cnt   <= '0;
            first_fail <= '0;
            for (int o = 0; o < N_OUT; o++) begin
              tt_row[o] <= '0;
            end
          end
        end
        ST_RUN: begin
          if (sample) begin
            for (int o = 0; o < N_OUT; o++) begin
              tt_row[o][vidx] <= resp[o];
            end
            fail_cnt <= fail_nxt;
            if (mismatch && (fail_cnt == '0)) begin
              first_fail <= vidx;
            end
            cnt <= '0;
            // Verdict is latched with the final count so it is already
            // valid in the done cycle.
            if (last) begin
              pass <= (fail_nxt == '0);
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnf_truth_table_sweeper.sv
// tb/tb_cnf_truth_table_sweeper.sv - directed self-checking bench for cnf_truth_table_sweeper
module tb_cnf_truth_table_sweeper;

  localparam logic [79:0] GOLD   = {16'h3333, 16'hFFAA, 16'hF000, 16'h6666, 16'h9A16};
  localparam logic [79:0] FAULTY = {16'h3333, 16'hFFAA, 16'hF420, 16'h6666, 16'h9A16};

  logic        clk;
  logic        rst_n;
  int          nvec;
  int          nerr;

  // default instance (SETTLE=1)
  logic        start;
  logic [79:0] exp_tt;
  logic [3:0]  stim;
  logic [4:0]  resp;
  logic        busy, done, pass;
  logic [79:0] tt_out;
  logic [4:0]  fail_cnt;
  logic [3:0]  first_fail;
  logic        inject;

  // SETTLE=0 instance
  logic        start_s0;
  logic [3:0]  stim_s0;
  logic [4:0]  resp_s0;
  logic        busy_s0, done_s0, pass_s0;
  logic [79:0] tt_s0;
  logic [4:0]  fc_s0;
  logic [3:0]  ff_s0;
  logic        dly_s0;
  logic [4:0]  p0_q;

  // SETTLE=3 instance
  logic        start_s3;
  logic [3:0]  stim_s3;
  logic [4:0]  resp_s3;
  logic        busy_s3, done_s3, pass_s3;
  logic [79:0] tt_s3;
  logic [4:0]  fc_s3;
  logic [3:0]  ff_s3;
  logic        dly_s3;
  logic [4:0]  p3_1, p3_2, p3_3, p3_4;

  logic [79:0] exp_gold;

  cnf_truth_table_sweeper u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .exp_tt(exp_tt), .stim(stim), .resp(resp),
    .busy(busy), .done(done), .pass(pass), .tt_out(tt_out), .fail_cnt(fail_cnt),
    .first_fail(first_fail)
  );

  cnf_truth_table_sweeper #(.N_IN(4), .N_OUT(5), .SETTLE(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start_s0), .exp_tt(exp_gold), .stim(stim_s0), .resp(resp_s0),
    .busy(busy_s0), .done(done_s0), .pass(pass_s0), .tt_out(tt_s0), .fail_cnt(fc_s0),
    .first_fail(ff_s0)
  );

  cnf_truth_table_sweeper #(.N_IN(4), .N_OUT(5), .SETTLE(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .start(start_s3), .exp_tt(exp_gold), .stim(stim_s3), .resp(resp_s3),
    .busy(busy_s3), .done(done_s3), .pass(pass_s3), .tt_out(tt_s3), .fail_cnt(fc_s3),
    .first_fail(ff_s3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural circuit: f0 = minterms {1,2,4,9,11,12,15}, f1 = x0^x1,
  // f2 = x2&x3, f3 = x0|x3, f4 = ~x1.
  function automatic logic [4:0] model(input logic [3:0] s);
    logic f0;
    case (s)
      4'd1, 4'd2, 4'd4, 4'd9, 4'd11, 4'd12, 4'd15: f0 = 1'b1;
      default:                                       f0 = 1'b0;
    endcase
    return {~s[1], s[0] | s[3], s[2] & s[3], s[0] ^ s[1], f0};
  endfunction

  always_comb begin
    resp = model(stim);
    if (inject && ((stim == 4'd5) || (stim == 4'd10))) begin
      resp[2] = ~resp[2];
    end
  end

  always @(posedge clk) begin
    p0_q <= model(stim_s0);
    p3_1 <= model(stim_s3);
    p3_2 <= p3_1;
    p3_3 <= p3_2;
    p3_4 <= p3_3;
  end

  assign resp_s0 = dly_s0 ? p0_q : model(stim_s0);
  assign resp_s3 = dly_s3 ? p3_4 : p3_3;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start    = v;
      1:       start_s0 = v;
      default: start_s3 = v;
    endcase
  endtask

  task automatic kick(input int sel);
    set_start(sel, 1'b1);
    step();
  endtask

  // Called at the first observation after the start edge (cycle 1). Checks the
  // stim sequence each RUN cycle and returns the cycle number where done is seen.
  task automatic wait_done(input int sel, input int settle, input int pulse_at,
                           input int limit, output int ncyc);
    logic       d;
    logic [3:0] s;
    ncyc = -1;
    for (int n = 1; n <= limit; n++) begin
      case (sel)
        0:       begin d = done;    s = stim;    end
        1:       begin d = done_s0; s = stim_s0; end
        default: begin d = done_s3; s = stim_s3; end
      endcase
      if (d) begin
        ncyc = n;
        break;
      end
      chk("stim_seq", 80'(s), 80'((n - 1) / (settle + 1)));
      set_start(sel, n == pulse_at);
      step();
    end
    set_start(sel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_seen;
    int bad;
    nvec     = 0;
    nerr     = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    start_s0 = 1'b0;
    start_s3 = 1'b0;
    inject   = 1'b0;
    dly_s0   = 1'b0;
    dly_s3   = 1'b0;
    exp_tt   = GOLD;
    exp_gold = GOLD;
    step();
    step();

    chk("rst_stim",       80'(stim),       80'd0);
    chk("rst_busy",       80'(busy),       80'd0);
    chk("rst_done",       80'(done),       80'd0);
    chk("rst_pass",       80'(pass),       80'd0);
    chk("rst_tt",         tt_out,          80'd0);
    chk("rst_fail_cnt",   80'(fail_cnt),   80'd0);
    chk("rst_first_fail", 80'(first_fail), 80'd0);
    rst_n = 1'b1;
    step();

    // Golden sweep with a stray start pulse at RUN cycle 10.
    kick(0);
    chk("start_busy", 80'(busy), 80'd1);
    chk("start_stim", 80'(stim), 80'd0);
    wait_done(0, 1, 10, 60, n);
    chk("gold_latency",    80'(n),          80'd33);
    chk("gold_busy_drop",  80'(busy),       80'd0);
    chk("gold_tt",         tt_out,          GOLD);
    chk("gold_tt_f0",      80'(tt_out[15:0]), 80'h9A16);
    chk("gold_pass",       80'(pass),       80'd1);
    chk("gold_fail_cnt",   80'(fail_cnt),   80'd0);
    chk("gold_first_fail", 80'(first_fail), 80'd0);
    // start during DONE is not queued
    start = 1'b1;
    step();
    start = 1'b0;
    chk("done_start_ignored", 80'(busy), 80'd0);
    chk("done_pulse_width",   80'(done), 80'd0);
    step();
    chk("done_start_not_queued", 80'(busy), 80'd0);
    chk("pass_persist",          80'(pass), 80'd1);

    // Injected fault on f2 at vectors 5 and 10.
    inject = 1'b1;
    kick(0);
    wait_done(0, 1, 0, 60, n);
    chk("fault_latency",    80'(n),          80'd33);
    chk("fault_fail_cnt",   80'(fail_cnt),   80'd2);
    chk("fault_first_fail", 80'(first_fail), 80'd5);
    chk("fault_pass",       80'(pass),       80'd0);
    chk("fault_tt",         tt_out,          FAULTY);
    // start held high across DONE restarts after one IDLE cycle
    start = 1'b1;
    step();
    chk("hold_idle_busy",     80'(busy),     80'd0);
    chk("hold_idle_results",  80'(fail_cnt), 80'd2);
    step();
    chk("hold_restart_busy",  80'(busy),       80'd1);
    chk("hold_clear_tt",      tt_out,          80'd0);
    chk("hold_clear_fc",      80'(fail_cnt),   80'd0);
    chk("hold_clear_ff",      80'(first_fail), 80'd0);
    chk("hold_clear_pass",    80'(pass),       80'd0);
    wait_done(0, 1, 0, 60, n);
    chk("hold_latency",  80'(n),        80'd33);
    chk("hold_fail_cnt", 80'(fail_cnt), 80'd2);
    step();
    inject = 1'b0;

    // Every vector mismatches.
    exp_tt = ~GOLD;
    kick(0);
    wait_done(0, 1, 0, 60, n);
    chk("allfail_latency",    80'(n),          80'd33);
    chk("allfail_fail_cnt",   80'(fail_cnt),   80'd16);
    chk("allfail_first_fail", 80'(first_fail), 80'd0);
    chk("allfail_pass",       80'(pass),       80'd0);
    chk("allfail_tt",         tt_out,          GOLD);
    exp_tt = GOLD;
    step();

    // SETTLE=0, combinational circuit then one-cycle-late circuit.
    kick(1);
    wait_done(1, 0, 0, 40, n);
    chk("s0_latency", 80'(n),       80'd17);
    chk("s0_pass",    80'(pass_s0), 80'd1);
    chk("s0_tt",      tt_s0,        GOLD);
    step();
    dly_s0 = 1'b1;
    kick(1);
    wait_done(1, 0, 0, 40, n);
    chk("s0_late_latency", 80'(n),       80'd17);
    chk("s0_late_pass",    80'(pass_s0), 80'd0);
    step();

    // SETTLE=3, three-cycle-late circuit then four-cycle-late circuit.
    kick(2);
    wait_done(2, 3, 0, 100, n);
    chk("s3_latency", 80'(n),       80'd65);
    chk("s3_pass",    80'(pass_s3), 80'd1);
    chk("s3_tt",      tt_s3,        GOLD);
    step();
    dly_s3 = 1'b1;
    kick(2);
    wait_done(2, 3, 0, 100, n);
    chk("s3_late_latency", 80'(n),       80'd65);
    chk("s3_late_pass",    80'(pass_s3), 80'd0);
    step();

    // Asynchronous reset at vector 7 with a partial failing result.
    inject = 1'b1;
    kick(0);
    start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (stim == 4'd7) break;
      step();
    end
    chk("mid_run_vector", 80'(stim), 80'd7);
    chk("mid_run_partial_fc", 80'(fail_cnt), 80'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_stim",       80'(stim),       80'd0);
    chk("arst_busy",       80'(busy),       80'd0);
    chk("arst_done",       80'(done),       80'd0);
    chk("arst_pass",       80'(pass),       80'd0);
    chk("arst_tt",         tt_out,          80'd0);
    chk("arst_fail_cnt",   80'(fail_cnt),   80'd0);
    chk("arst_first_fail", 80'(first_fail), 80'd0);
    step();
    rst_n     = 1'b1;
    done_seen = 0;
    bad       = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (done) done_seen++;
      if (busy || (stim != 4'd0)) bad++;
    end
    chk("post_rst_done_pulses", 80'(done_seen), 80'd0);
    chk("post_rst_idle_bad",    80'(bad),       80'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
